// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges ID/EX/MEM stall requests and exception flush
// into the per-stage hold vector, and owns the EX multi-cycle occupancy counter.
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_cycles,
    input  logic              ex_mc_cancel,
    input  logic              stallreq_mem,
    input  logic              flush_req,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [PERF_W-1:0]   stall_cycles_q;
    logic                mcLong;
    logic                exStall;

    assign mcLong = (ex_mc_cycles >= CNT_W'(2));

    // The final EX cycle (remaining==1) releases the stall so the result can advance.
    always_comb begin
        exStall = 1'b0;
        if (state_q == IDLE) begin
            exStall = ex_mc_start && mcLong && !ex_mc_cancel;
        end else begin
            exStall = (remaining_q != CNT_W'(1)) && !ex_mc_cancel;
        end
    end

    always_comb begin
        stall = 6'b000000;
        flush = 1'b0;
        if (!rst) begin
            if (flush_req) begin
                flush = 1'b1;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (exStall) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (flush_req || ex_mc_cancel) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else if (state_q == IDLE) begin
            if (ex_mc_start && mcLong) begin
                state_d     = MC_BUSY;
                remaining_d = ex_mc_cycles - CNT_W'(1);
            end
        end else if (!stallreq_mem) begin
            if (remaining_q > CNT_W'(1)) begin
                remaining_d = remaining_q - CNT_W'(1);
            end else begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            if ((stall != 6'b000000) && (stall_cycles_q != {PERF_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            end
        end
    end

    assign mc_busy      = (state_q == MC_BUSY);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the stall/flush rules.
module tb_pipe_stall_ctrl;

    localparam int CNT_W  = 6;
    localparam int PERF_W = 6;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_id;
    logic              ex_mc_start;
    logic [CNT_W-1:0]  ex_mc_cycles;
    logic              ex_mc_cancel;
    logic              stallreq_mem;
    logic              flush_req;
    logic [5:0]        stall;
    logic              flush;
    logic              mc_busy;
    logic [PERF_W-1:0] stall_cycles;

    typedef struct {
        logic [5:0]        stall;
        logic              flush;
        logic              mcBusy;
        logic [PERF_W-1:0] cycles;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   mcLeft = 0;
    int   stallCnt = 0;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .ex_mc_cancel (ex_mc_cancel),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .stall        (stall),
        .flush        (flush),
        .mc_busy      (mc_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mcLeft counts the EX cycles the current op still needs, including the release cycle.
    task automatic applyStimulus(input logic id, input logic start, input int n,
                                 input logic cancel, input logic mem, input logic fl);
        exp_t e;
        int   nn;
        logic busy;
        logic exS;
        @(negedge clk);
        nn           = n & ((1 << CNT_W) - 1);
        stallreq_id  = id;
        ex_mc_start  = start;
        ex_mc_cycles = nn[CNT_W-1:0];
        ex_mc_cancel = cancel;
        stallreq_mem = mem;
        flush_req    = fl;
        busy = (mcLeft > 0);
        exS  = busy ? ((mcLeft != 1) && !cancel) : (start && nn >= 2 && !cancel);
        e.flush  = fl;
        e.stall  = fl ? 6'b000000 : mem ? 6'b011111 : exS ? 6'b001111 : id ? 6'b000111 : 6'b000000;
        e.mcBusy = busy;
        e.cycles = stallCnt[PERF_W-1:0];
        #1;
        expQ.push_back(e);
        if (fl || cancel) begin
            mcLeft = 0;
        end else if (!busy) begin
            if (start && nn >= 2) mcLeft = nn - 1;
        end else if (!mem) begin
            mcLeft = mcLeft - 1;
        end
        if (e.stall != 6'b000000 && stallCnt < PERF_MAX) stallCnt++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic randomPhase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8));
            applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, n,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 49) == 0);
        end
    endtask

    // Asserts reset between clock edges with requests active; outputs must clear at once.
    task automatic resetMidCycle();
        #2;
        rst          = 1'b1;
        flush_req    = 1'b1;
        stallreq_mem = 1'b1;
        #1;
        checkOutput("asyncRstStall", 32'(stall), 32'h0);
        checkOutput("asyncRstFlush", 32'(flush), 32'h0);
        checkOutput("asyncRstBusy", 32'(mc_busy), 32'h0);
        checkOutput("asyncRstCycles", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = '0;
        ex_mc_cancel = 1'b0; stallreq_mem = 1'b0; flush_req = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        mcLeft   = 0;
        stallCnt = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("stall", 32'(stall), 32'(e.stall));
                checkOutput("flush", 32'(flush), 32'(e.flush));
                checkOutput("mc_busy", 32'(mc_busy), 32'(e.mcBusy));
                checkOutput("stall_cycles", 32'(stall_cycles), 32'(e.cycles));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        rst = 1'b1;
        stallreq_id = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 6'd5;
        ex_mc_cancel = 1'b0; stallreq_mem = 1'b1; flush_req = 1'b1;
        #3;
        checkOutput("rstStall", 32'(stall), 32'h0);
        checkOutput("rstFlush", 32'(flush), 32'h0);
        @(negedge clk);
        stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = '0;
        stallreq_mem = 1'b0; flush_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        idle(3);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(5);
        applyStimulus(1'b0, 1'b1, 33, 1'b0, 1'b0, 1'b0);
        idle(8);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(6);
        applyStimulus(1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        idle(6);

        randomPhase(400);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0);
        idle(3);
        resetMidCycle();
        idle(2);
        randomPhase(400);

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
